// File: rtl/po_signature_compactor.sv
// Serial-input MISR response compactor: folds one response bit per accepted
// cycle into a signature and compares it with a golden value at run end.
module po_signature_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [SIG_W-1:0] golden,
    input  logic             po_valid,
    input  logic             po0,
    output logic             po_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nvec_q;
    logic             pass_q;

    logic             xfer;
    logic             last;
    logic             launch;
    logic [SIG_W-1:0] sig_next;

    // Handshake outputs come from registered state only, never from po_valid.
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign po_ready  = busy;
    assign pass      = pass_q;
    assign signature = sig_q;
    assign vec_count = cnt_q;

    assign launch   = start && !abort && (state_q != RUN);
    assign xfer     = busy && po_valid && !abort;
    assign last     = (cnt_q == nvec_q - CNT_W'(1));
    assign sig_next = {sig_q[SIG_W-2:0], 1'b0}
                    ^ (sig_q[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, po0};

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE: if (start) state_d = (num_vec == '0) ? DONE : RUN;
                RUN:        if (xfer && last) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            nvec_q <= '0;
            pass_q <= 1'b0;
        end else if (abort) begin
            pass_q <= 1'b0;
        end else if (launch) begin
            sig_q  <= SEED;
            cnt_q  <= '0;
            nvec_q <= num_vec;
            // A zero-length run completes immediately on the seed value.
            pass_q <= (num_vec == '0) && (SEED == golden);
        end else if (xfer) begin
            sig_q <= sig_next;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) pass_q <= (sig_next == golden);
        end
    end

endmodule

// File: tb/tb_po_signature_compactor.sv
// Self-checking bench for po_signature_compactor: directed scenarios plus
// randomized runs checked against an arithmetic MISR model.
module tb_po_signature_compactor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] num_vec = '0;
    logic [15:0] golden = '0;
    logic        po_valid = 1'b0;
    logic        po0 = 1'b0;
    logic        po_ready, busy, done, pass;
    logic [15:0] signature, vec_count;

    int tests_run = 0;
    int tests_failed = 0;
    bit bitvec[64];

    po_signature_compactor dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_vec(num_vec), .golden(golden), .po_valid(po_valid), .po0(po0),
        .po_ready(po_ready), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    // Signature as polynomial arithmetic: double, reduce by x^16+POLY on overflow, add bit.
    function automatic logic [15:0] model_sig(input int n);
        int s = 'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = s * 2;
            if (s >= 65536) s = (s - 65536) ^ 'h1021;
            s = s ^ int'(bitvec[i]);
        end
        return s[15:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (signature !== 16'hFFFF || vec_count !== 16'd0 || done !== 1'b0 ||
            pass !== 1'b0 || busy !== 1'b0 || po_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: sig=%h cnt=%0d done=%b pass=%b busy=%b rdy=%b, want FFFF/0/0/0/0/0",
                     signature, vec_count, done, pass, busy, po_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        num_vec = 16'd1; golden = 16'hEFDE; start = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || po_ready !== 1'b1 || signature !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL single_start: busy=%b rdy=%b sig=%h, want 1/1/FFFF", busy, po_ready, signature);
        end
        po_valid = 1'b1; po0 = 1'b1;
        step();
        po_valid = 1'b0;
        tests_run++;
        if (signature !== 16'hEFDE || vec_count !== 16'd1 || done !== 1'b1 ||
            pass !== 1'b1 || po_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: sig=%h cnt=%0d done=%b pass=%b rdy=%b, want EFDE/1/1/1/0",
                     signature, vec_count, done, pass, po_ready);
        end
    endtask

    task automatic test_bubble();
        num_vec = 16'd2; golden = 16'hCF9E; start = 1'b1;
        step();
        start = 1'b0;
        po_valid = 1'b1; po0 = 1'b0;
        step();
        po_valid = 1'b0;
        tests_run++;
        if (signature !== 16'hEFDF || vec_count !== 16'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL bubble_mid: sig=%h cnt=%0d busy=%b, want EFDF/1/1", signature, vec_count, busy);
        end
        repeat (3) step();
        tests_run++;
        if (signature !== 16'hEFDF || vec_count !== 16'd1 || busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_hold: sig=%h cnt=%0d busy=%b done=%b, want EFDF/1/1/0",
                     signature, vec_count, busy, done);
        end
        po_valid = 1'b1; po0 = 1'b0;
        step();
        po_valid = 1'b0;
        tests_run++;
        if (signature !== 16'hCF9F || vec_count !== 16'd2 || done !== 1'b1 || pass !== 1'b0) begin
            tests_failed++;
            $display("FAIL bubble_end: sig=%h cnt=%0d done=%b pass=%b, want CF9F/2/1/0",
                     signature, vec_count, done, pass);
        end
    endtask

    task automatic test_zero();
        bit saw_ready = 1'b0;
        num_vec = 16'd0; golden = 16'hFFFF; start = 1'b1;
        saw_ready = saw_ready | po_ready;
        step();
        start = 1'b0;
        saw_ready = saw_ready | po_ready;
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd0 || signature !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL zero: done=%b pass=%b cnt=%0d sig=%h, want 1/1/0/FFFF", done, pass, vec_count, signature);
        end
        step();
        saw_ready = saw_ready | po_ready;
        tests_run++;
        if (saw_ready !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_ready: saw_ready=%b done=%b, want 0/1", saw_ready, done);
        end
    endtask

    task automatic test_abort();
        logic [15:0] exp;
        // Abort out of DONE with pass=1 left by the zero-vector run.
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_done: done=%b pass=%b busy=%b, want 0/0/0", done, pass, busy);
        end
        bitvec[0] = 1'b1; bitvec[1] = 1'b0; bitvec[2] = 1'b1;
        num_vec = 16'd5; golden = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            po_valid = 1'b1; po0 = bitvec[i];
            step();
        end
        po_valid = 1'b0;
        // A start in RUN with a different count must neither relatch nor reseed.
        num_vec = 16'd3; start = 1'b1;
        step();
        start = 1'b0;
        exp = model_sig(2);
        tests_run++;
        if (busy !== 1'b1 || signature !== exp || vec_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL start_in_run: busy=%b sig=%h cnt=%0d, want 1/%h/2", busy, signature, vec_count, exp);
        end
        po_valid = 1'b1; po0 = bitvec[2];
        step();
        po_valid = 1'b0;
        exp = model_sig(3);
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || signature !== exp || vec_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL start_relatch: busy=%b done=%b sig=%h cnt=%0d, want 1/0/%h/3",
                     busy, done, signature, vec_count, exp);
        end
        abort = 1'b1; po_valid = 1'b1; po0 = 1'b1;
        step();
        abort = 1'b0; po_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || signature !== exp || vec_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL abort_run: busy=%b done=%b pass=%b sig=%h cnt=%0d, want 0/0/0/%h/3",
                     busy, done, pass, signature, vec_count, exp);
        end
    endtask

    task automatic test_reset_mid();
        num_vec = 16'd10; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            po_valid = 1'b1; po0 = 1'($urandom);
            step();
        end
        po_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (signature !== 16'hFFFF || vec_count !== 16'd0 || done !== 1'b0 ||
            po_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: sig=%h cnt=%0d done=%b rdy=%b busy=%b, want FFFF/0/0/0/0",
                     signature, vec_count, done, po_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int          n = $urandom_range(1, 40);
            int          idx = 0;
            bit          exp_pass = 1'($urandom);
            logic [15:0] m;
            for (int i = 0; i < n; i++) bitvec[i] = 1'($urandom);
            m = model_sig(n);
            golden = exp_pass ? m : (m ^ 16'(1 << $urandom_range(0, 15)));
            num_vec = 16'(n); start = 1'b1;
            step();
            start = 1'b0;
            for (int c = 0; c < 400 && idx < n; c++) begin
                po_valid = ($urandom_range(0, 3) != 0);
                po0 = bitvec[idx];
                if (po_valid && po_ready !== 1'b1) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL rand_ready: run=%0d idx=%0d rdy=%b, want 1", r, idx, po_ready);
                end
                step();
                if (po_valid) idx++;
            end
            po_valid = 1'b0;
            tests_run++;
            if (idx < n || done !== 1'b1 || signature !== m || vec_count !== 16'(n) || pass !== exp_pass) begin
                tests_failed++;
                $display("FAIL rand_run%0d: sent=%0d done=%b sig=%h cnt=%0d pass=%b, want %0d/1/%h/%0d/%b",
                         r, idx, done, signature, vec_count, pass, n, m, n, exp_pass);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] sig_iso;
        int n = 6;
        for (int i = 0; i < n; i++) bitvec[i] = 1'($urandom);
        golden = model_sig(n);
        num_vec = 16'(n); start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            po_valid = 1'b1; po0 = bitvec[i];
            step();
        end
        po_valid = 1'b0;
        sig_iso = signature;
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || sig_iso !== model_sig(n)) begin
            tests_failed++;
            $display("FAIL b2b_iso: done=%b pass=%b sig=%h, want 1/1/%h", done, pass, sig_iso, model_sig(n));
        end
        // Restart straight from DONE, presenting the first bit already.
        start = 1'b1; po_valid = 1'b1; po0 = bitvec[0];
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || signature !== 16'hFFFF || vec_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL b2b_restart: busy=%b done=%b sig=%h cnt=%0d, want 1/0/FFFF/0",
                     busy, done, signature, vec_count);
        end
        for (int i = 0; i < n; i++) begin
            po_valid = 1'b1; po0 = bitvec[i];
            step();
        end
        po_valid = 1'b0;
        tests_run++;
        if (done !== 1'b1 || pass !== 1'b1 || signature !== sig_iso || vec_count !== 16'(n)) begin
            tests_failed++;
            $display("FAIL b2b_second: done=%b pass=%b sig=%h cnt=%0d, want 1/1/%h/%0d",
                     done, pass, signature, vec_count, sig_iso, n);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bubble();
        test_zero();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
